// File: rtl/encoder_fec_pkg.sv
// Shared types and defaults for the FEC encoder front end.
package encoder_fec_pkg;

    typedef enum logic [1:0] {SCH_IDLE, SCH_BURST, SCH_DRAIN} sched_state_t;

    localparam int FEC_BLK_WORDS = 8;
    localparam int FEC_ENTRIES   = 1024;

endpackage

// File: rtl/msg_fifo_sched_occ_counter.sv
// Saturating up/down occupancy counter for the message FIFO.
// A write is refused at ENTRIES-1 even when a read happens in the same cycle.
module occ_counter #(
    parameter int ENTRIES = 1024,
    parameter int CNT_W   = $clog2(ENTRIES) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_not_full
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ENTRIES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_inc && !i_dec && (r_count < CNT_MAX)) begin
            r_count <= r_count + CNT_W'(1);
        end else if (i_dec && !i_inc && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_count    = r_count;
    assign o_not_full = (r_count < CNT_MAX);

endmodule

// File: rtl/msg_fifo_sched.sv
// Message FIFO scheduler: throttles producer writes and reads the FIFO out in
// whole blocks of BLK_WORDS words once a full block is stored and the encoder is ready.
module msg_fifo_sched
    import encoder_fec_pkg::*;
#(
    parameter int ENTRIES   = FEC_ENTRIES,
    parameter int BLK_WORDS = FEC_BLK_WORDS,
    parameter int CNT_W     = $clog2(ENTRIES) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             fifo_wr_en,
    output logic             fifo_rd_en,
    input  logic             fifo_rd_valid,
    input  logic             fifo_full,
    input  logic             enc_ready,
    output logic             enc_valid,
    output logic             enc_sob,
    output logic             enc_eob,
    output logic [CNT_W-1:0] occupancy,
    output logic             err
);

    localparam int               IDX_W    = (BLK_WORDS > 1) ? $clog2(BLK_WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLK_WORDS - 1);
    localparam logic [CNT_W-1:0] BLK_CNT  = CNT_W'(BLK_WORDS);

    sched_state_t     r_st;
    sched_state_t     w_st_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [IDX_W-1:0] r_idx_q;
    logic             r_rd_q;
    logic             r_err;
    logic             w_rd_en;
    logic             w_wr_en;
    logic             w_in_ready;
    logic [CNT_W-1:0] w_occ;

    occ_counter #(
        .ENTRIES (ENTRIES),
        .CNT_W   (CNT_W)
    ) u_occ (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_inc      (w_wr_en),
        .i_dec      (w_rd_en),
        .o_count    (w_occ),
        .o_not_full (w_in_ready)
    );

    assign w_wr_en = in_valid & w_in_ready;

    // Decision uses registered occupancy, so a same-cycle write never triggers a burst.
    always_comb begin
        w_st_nxt  = r_st;
        w_idx_nxt = r_idx;
        w_rd_en   = 1'b0;
        case (r_st)
            SCH_IDLE: begin
                if ((w_occ >= BLK_CNT) && enc_ready) begin
                    w_st_nxt  = SCH_BURST;
                    w_idx_nxt = '0;
                end
            end
            SCH_BURST: begin
                w_rd_en = 1'b1;
                if (r_idx == IDX_LAST) begin
                    w_st_nxt = SCH_DRAIN;
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            SCH_DRAIN: begin
                w_st_nxt = SCH_IDLE;
            end
            default: begin
                w_st_nxt = SCH_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st    <= SCH_IDLE;
            r_idx   <= '0;
            r_idx_q <= '0;
            r_rd_q  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_st    <= w_st_nxt;
            r_idx   <= w_idx_nxt;
            r_idx_q <= r_idx;
            r_rd_q  <= w_rd_en;
            // rd_valid is only meaningful for the word read on the previous edge.
            r_err   <= r_err | (r_rd_q & ~fifo_rd_valid) | (w_wr_en & fifo_full);
        end
    end

    assign in_ready   = w_in_ready;
    assign fifo_wr_en = w_wr_en;
    assign fifo_rd_en = w_rd_en;
    assign occupancy  = w_occ;
    assign enc_valid  = r_rd_q;
    assign enc_sob    = r_rd_q & (r_idx_q == '0);
    assign enc_eob    = r_rd_q & (r_idx_q == IDX_LAST);
    assign err        = r_err;

endmodule

// File: tb/tb_msg_fifo_sched.sv
// Self-checking bench for msg_fifo_sched: a queue-based FIFO environment, a
// counter-level reference model with a negedge scoreboard, and scenario tasks.
module tb_msg_fifo_sched;

    localparam int E   = 32;
    localparam int BLK = 8;
    localparam int CW  = $clog2(E) + 1;
    localparam int E2  = 16;
    localparam int CW2 = $clog2(E2) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance (block of 8)
    logic          in_valid = 1'b0, enc_ready = 1'b0;
    logic [7:0]    wdata = '0;
    logic          in_ready, fifo_wr_en, fifo_rd_en, fifo_rd_valid, fifo_full;
    logic          enc_valid, enc_sob, enc_eob, err;
    logic [CW-1:0] occupancy;

    // second instance (capacity 15, block of 1)
    logic           in_valid2 = 1'b0, enc_ready2 = 1'b0, one = 1'b1;
    logic           in_ready2, wr2, rd2, full2, ev2, sob2, eob2, err2;
    logic [CW2-1:0] occ2;

    int errors = 0;
    int checks = 0;

    msg_fifo_sched #(.ENTRIES(E), .BLK_WORDS(BLK)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .fifo_rd_valid(fifo_rd_valid),
        .fifo_full(fifo_full), .enc_ready(enc_ready), .enc_valid(enc_valid),
        .enc_sob(enc_sob), .enc_eob(enc_eob), .occupancy(occupancy), .err(err)
    );

    msg_fifo_sched #(.ENTRIES(E2), .BLK_WORDS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .fifo_wr_en(wr2), .fifo_rd_en(rd2), .fifo_rd_valid(one),
        .fifo_full(full2), .enc_ready(enc_ready2), .enc_valid(ev2),
        .enc_sob(sob2), .enc_eob(eob2), .occupancy(occ2), .err(err2)
    );

    // FIFO environment for the main instance
    logic [7:0] fq[$];
    logic [7:0] fdata;
    logic       fvalid;
    logic       inj_bad = 1'b0;
    int         fcnt;
    assign fifo_rd_valid = fvalid & ~inj_bad;
    assign fifo_full     = (fcnt >= E - 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
            fvalid <= 1'b0;
            fdata  <= '0;
            fcnt   <= 0;
        end else begin
            if (fifo_rd_en) begin
                if (fq.size() > 0) begin
                    fdata  <= fq.pop_front();
                    fvalid <= 1'b1;
                end else begin
                    fvalid <= 1'b0;
                end
            end
            if (fifo_wr_en) fq.push_back(wdata);
            fcnt <= fcnt + (fifo_wr_en ? 1 : 0) - ((fifo_rd_en && fcnt > 0) ? 1 : 0);
        end
    end

    // FIFO fill level for the second instance
    int cnt2;
    assign full2 = (cnt2 >= E2 - 1);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt2 <= 0;
        else        cnt2 <= cnt2 + (wr2 ? 1 : 0) - ((rd2 && cnt2 > 0) ? 1 : 0);
    end

    // Reference model: words stored, burst words remaining, one quiet cycle after a burst
    logic [7:0] mq[$];
    int         m_occ, m_bl, m_pos;
    bit         m_drain, m_vq, m_err;
    logic [7:0] m_dexp;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_occ <= 0; m_bl <= 0; m_pos <= 0;
            m_drain <= 1'b0; m_vq <= 1'b0; m_err <= 1'b0; m_dexp <= '0;
        end else begin
            if (m_bl > 0) begin
                m_vq   <= 1'b1;
                m_pos  <= BLK - m_bl;
                m_dexp <= mq.pop_front();
            end else begin
                m_vq <= 1'b0;
            end
            if (in_valid && m_occ < E - 1) mq.push_back(wdata);
            m_occ <= m_occ + ((in_valid && m_occ < E - 1) ? 1 : 0) - ((m_bl > 0) ? 1 : 0);
            if (m_bl > 0) begin
                m_bl <= m_bl - 1;
                if (m_bl == 1) m_drain <= 1'b1;
            end else if (m_drain) begin
                m_drain <= 1'b0;
            end else if (m_occ >= BLK && enc_ready) begin
                m_bl <= BLK;
            end
            m_err <= m_err || (m_vq && !fifo_rd_valid) || (in_valid && m_occ < E - 1 && fifo_full);
        end
    end

    // Scoreboard on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (occupancy !== CW'(m_occ)) begin
                errors++; $display("FAIL occupancy t=%0t got=%0d exp=%0d", $time, occupancy, m_occ);
            end
            checks++;
            if (in_ready !== (m_occ < E - 1)) begin
                errors++; $display("FAIL in_ready t=%0t got=%b exp=%b", $time, in_ready, m_occ < E - 1);
            end
            checks++;
            if (fifo_wr_en !== (in_valid && m_occ < E - 1)) begin
                errors++; $display("FAIL fifo_wr_en t=%0t got=%b exp=%b", $time, fifo_wr_en, in_valid && m_occ < E - 1);
            end
            checks++;
            if (fifo_rd_en !== (m_bl > 0)) begin
                errors++; $display("FAIL fifo_rd_en t=%0t got=%b exp=%b", $time, fifo_rd_en, m_bl > 0);
            end
            checks++;
            if ({enc_valid, enc_sob, enc_eob} !== {m_vq, m_vq && m_pos == 0, m_vq && m_pos == BLK - 1}) begin
                errors++; $display("FAIL enc_strobes t=%0t got=%b%b%b exp=%b%b%b pos=%0d", $time,
                                   enc_valid, enc_sob, enc_eob, m_vq, m_vq && m_pos == 0, m_vq && m_pos == BLK - 1, m_pos);
            end
            if (m_vq) begin
                checks++;
                if (fdata !== m_dexp) begin
                    errors++; $display("FAIL enc_data t=%0t got=%h exp=%h", $time, fdata, m_dexp);
                end
            end
            checks++;
            if (err !== m_err) begin
                errors++; $display("FAIL err t=%0t got=%b exp=%b", $time, err, m_err);
            end
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({fifo_wr_en, fifo_rd_en, enc_valid, enc_sob, enc_eob, err, in_ready, occupancy} !== {7'b0000001, CW'(0)}) begin
            errors++; $display("FAIL reset_outputs got=%b%b%b%b%b%b%b occ=%0d exp=0000001 occ=0",
                               fifo_wr_en, fifo_rd_en, enc_valid, enc_sob, enc_eob, err, in_ready, occupancy);
        end
        checks++;
        if ({wr2, rd2, ev2, sob2, eob2, err2, in_ready2, occ2} !== {7'b0000001, CW2'(0)}) begin
            errors++; $display("FAIL reset_outputs_blk1 got=%b%b%b%b%b%b%b occ=%0d exp=0000001 occ=0",
                               wr2, rd2, ev2, sob2, eob2, err2, in_ready2, occ2);
        end
        @(posedge clk); #2 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || occupancy !== CW'(0)) begin
            errors++; $display("FAIL after_reset in_ready=%b occ=%0d exp 1/0", in_ready, occupancy);
        end
    endtask

    task automatic test_block8();
        int nrd = 0, k = 0;
        @(posedge clk); #1 enc_ready = 1'b1;
        for (int i = 0; i < BLK; i++) begin
            in_valid = 1'b1; wdata = 8'h10 + 8'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (fifo_rd_en) nrd++;
            if (enc_valid) begin
                checks++;
                if (fdata !== 8'h10 + 8'(k) || enc_sob !== (k == 0) || enc_eob !== (k == BLK - 1)) begin
                    errors++; $display("FAIL block8_word%0d got data=%h sob=%b eob=%b exp data=%h sob=%b eob=%b",
                                       k, fdata, enc_sob, enc_eob, 8'h10 + 8'(k), k == 0, k == BLK - 1);
                end
                k++;
            end
        end
        checks++;
        if (nrd != BLK || k != BLK) begin
            errors++; $display("FAIL block8_count reads=%0d words=%0d exp %0d", nrd, k, BLK);
        end
        checks++;
        if (occupancy !== CW'(0)) begin
            errors++; $display("FAIL block8_occ got=%0d exp=0", occupancy);
        end
    endtask

    task automatic test_below_threshold();
        for (int i = 0; i < BLK - 1; i++) begin
            in_valid = 1'b1; wdata = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (fifo_rd_en !== 1'b0) begin
                errors++; $display("FAIL below_thr_rd cycle=%0d got=%b exp=0", c, fifo_rd_en);
            end
        end
        in_valid = 1'b1; wdata = 8'($urandom);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (occupancy !== CW'(BLK) || fifo_rd_en !== 1'b0) begin
            errors++; $display("FAIL below_thr_decide occ=%0d rd=%b exp occ=%0d rd=0", occupancy, fifo_rd_en, BLK);
        end
        @(negedge clk);
        checks++;
        if (fifo_rd_en !== 1'b1) begin
            errors++; $display("FAIL below_thr_start got=%b exp=1", fifo_rd_en);
        end
        repeat (14) @(posedge clk);
        #1;
    endtask

    task automatic test_stall_concurrent();
        int nb = 0, gap = 0;
        logic prev = 1'b0;
        enc_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; wdata = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (fifo_rd_en !== 1'b0) begin
                errors++; $display("FAIL stall_rd cycle=%0d got=%b exp=0", c, fifo_rd_en);
            end
        end
        checks++;
        if (occupancy !== CW'(20)) begin
            errors++; $display("FAIL stall_occ got=%0d exp=20", occupancy);
        end
        @(posedge clk); #1 enc_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (fifo_rd_en && !prev) begin
                nb++;
                if (nb > 1) begin
                    checks++;
                    if (gap < 2) begin
                        errors++; $display("FAIL burst_gap got=%0d exp>=2", gap);
                    end
                end
                gap = 0;
            end else if (!fifo_rd_en) begin
                gap++;
            end
            prev = fifo_rd_en;
            @(posedge clk); #1;
            in_valid = 1'($urandom); wdata = 8'($urandom);
        end
        in_valid = 1'b0;
        checks++;
        if (nb < 2) begin
            errors++; $display("FAIL stall_bursts got=%0d exp>=2", nb);
        end
        repeat (50) @(posedge clk);
        #1;
    endtask

    task automatic test_err_inject();
        bit seen = 1'b0;
        enc_ready = 1'b1;
        for (int i = 0; i < BLK; i++) begin
            in_valid = 1'b1; wdata = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (enc_valid) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL err_wait_burst got=timeout exp=enc_valid");
        end
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL err_before got=%b exp=0", err);
        end
        inj_bad = 1'b1;
        @(posedge clk); #1 inj_bad = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            checks++;
            if (err !== 1'b1) begin
                errors++; $display("FAIL err_sticky cycle=%0d got=%b exp=1", c, err);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL err_reset got=%b exp=0", err);
        end
        @(posedge clk); #2 rst_n = 1'b1;
    endtask

    task automatic test_reset_mid_burst();
        int nrd = 0;
        enc_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; wdata = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 40 && nrd < 3; c++) begin
            @(negedge clk);
            if (fifo_rd_en) nrd++;
        end
        checks++;
        if (nrd != 3) begin
            errors++; $display("FAIL midrst_wait got=%0d reads exp=3", nrd);
        end
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({fifo_wr_en, fifo_rd_en, enc_valid, enc_sob, enc_eob, err, in_ready, occupancy} !== {7'b0000001, CW'(0)}) begin
            errors++; $display("FAIL midrst_async got=%b%b%b%b%b%b%b occ=%0d exp=0000001 occ=0",
                               fifo_wr_en, fifo_rd_en, enc_valid, enc_sob, enc_eob, err, in_ready, occupancy);
        end
        #4 rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (occupancy !== CW'(0) || in_ready !== 1'b1 || fifo_rd_en !== 1'b0 || enc_valid !== 1'b0) begin
                errors++; $display("FAIL midrst_after occ=%0d in_ready=%b rd=%b valid=%b exp 0/1/0/0",
                                   occupancy, in_ready, fifo_rd_en, enc_valid);
            end
        end
    endtask

    task automatic test_blk1_fill();
        int nwr = 0, nev = 0;
        logic prev_rd = 1'b0;
        @(posedge clk); #1;
        enc_ready2 = 1'b0; in_valid2 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (in_ready2 !== (nwr < E2 - 1)) begin
                errors++; $display("FAIL fill_in_ready writes=%0d got=%b exp=%b", nwr, in_ready2, nwr < E2 - 1);
            end
            checks++;
            if (wr2 && full2) begin
                errors++; $display("FAIL fill_wr_full got=wr_en with full exp=no write");
            end
            if (wr2) nwr++;
        end
        @(posedge clk); #1 in_valid2 = 1'b0;
        checks++;
        if (nwr != E2 - 1 || occ2 !== CW2'(E2 - 1) || err2 !== 1'b0) begin
            errors++; $display("FAIL fill_end writes=%0d occ=%0d err=%b exp %0d/%0d/0", nwr, occ2, err2, E2 - 1, E2 - 1);
        end
        enc_ready2 = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            checks++;
            if (sob2 !== ev2 || eob2 !== ev2) begin
                errors++; $display("FAIL blk1_strobes valid=%b got sob=%b eob=%b exp both=%b", ev2, sob2, eob2, ev2);
            end
            checks++;
            if (prev_rd && rd2) begin
                errors++; $display("FAIL blk1_gap got=back-to-back reads exp=gap");
            end
            if (ev2) nev++;
            prev_rd = rd2;
        end
        checks++;
        if (nev != E2 - 1 || occ2 !== CW2'(0) || err2 !== 1'b0) begin
            errors++; $display("FAIL blk1_drain words=%0d occ=%0d err=%b exp %0d/0/0", nev, occ2, err2, E2 - 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_block8();
        test_below_threshold();
        test_stall_concurrent();
        test_err_inject();
        test_reset_mid_burst();
        test_blk1_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
